// File: rtl/shift_load_pkg.sv
// Shared constants for the shift/load register: default width and select encoding.
package shift_load_pkg;

  localparam int SLR_WIDTH = 32;

  localparam logic SEL_SHIFT = 1'b0;
  localparam logic SEL_LOAD  = 1'b1;

endpackage : shift_load_pkg

// File: rtl/slr_bit_cell.sv
// One bit of the shift/load register: 2:1 mux (load bit vs. neighbour bit) into a flop with sync clear.
module slr_bit_cell
  import shift_load_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sel,
  input  logic load_bit,
  input  logic neighbour,
  output logic q
);

  // An X on sel is deliberately left to propagate into q rather than being masked.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      q <= (sel == SEL_LOAD) ? load_bit : neighbour;
    end
  end

endmodule : slr_bit_cell

// File: rtl/shift_load_reg32.sv
// Parallel-load / serial-right-shift register built from slr_bit_cell instances.
// Optional macro SERIAL_OUT_EN adds the shiftout port (equal to state[0]) for chaining.
module shift_load_reg32
  import shift_load_pkg::*;
#(
  parameter int WIDTH = SLR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load,
  input  logic             shiftin,
  input  logic             sel,
`ifdef SERIAL_OUT_EN
  output logic             shiftout,
`endif
  output logic [WIDTH-1:0] state
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == WIDTH - 1) begin : g_msb
      // The serial input enters at the MSB; every other bit takes its upper neighbour.
      slr_bit_cell u_cell (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .load_bit  (load[i]),
        .neighbour (shiftin),
        .q         (state[i])
      );
    end else begin : g_inner
      slr_bit_cell u_cell (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .load_bit  (load[i]),
        .neighbour (state[i+1]),
        .q         (state[i])
      );
    end
  end

`ifdef SERIAL_OUT_EN
  // state[0] is already a flop output, so shiftout stays registered.
  assign shiftout = state[0];
`endif

endmodule : shift_load_reg32

// File: tb/tb_shift_load_reg32.sv
// Self-checking bench for shift_load_reg32: vector table plus hand-written multi-cycle sequences.
module tb_shift_load_reg32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] load;
  logic         shiftin;
  logic         sel;
  logic [W-1:0] state;
`ifdef SERIAL_OUT_EN
  logic         shiftout;
`endif

  shift_load_reg32 #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shiftin  (shiftin),
    .sel      (sel),
`ifdef SERIAL_OUT_EN
    .shiftout (shiftout),
`endif
    .state    (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         reset;
    logic         sel;
    logic [W-1:0] load;
    logic         shiftin;
    logic [W-1:0] expect_state;
    string        name;
  } vec_t;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int so_ones = 0;

  // Drive one edge's inputs, queue the expected result, then compare after the edge.
  task automatic step(input logic r, input logic s, input logic [W-1:0] ld,
                      input logic si, input logic [W-1:0] expv, input string nm);
    logic [W-1:0] e;
    @(negedge clk);
    reset   = r;
    sel     = s;
    load    = ld;
    shiftin = si;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (state !== e) begin
      n_bad++;
      $display("FAIL %s: state got %08h want %08h", nm, state, e);
    end
`ifdef SERIAL_OUT_EN
    n_cmp++;
    if (shiftout !== e[0]) begin
      n_bad++;
      $display("FAIL %s shiftout: got %b want %b", nm, shiftout, e[0]);
    end
    if (shiftout === 1'b1) so_ones++;
`endif
  endtask

  vec_t vecs[$];

  initial begin
    reset   = 1'b1;
    sel     = 1'b0;
    load    = '0;
    shiftin = 1'b0;

    // Reset beats load and shift; then parallel loads with one-cycle latency.
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0001, 1'b1, 32'h0000_0000, "reset_shift0"});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0001, 1'b1, 32'h0000_0000, "reset_shift1"});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_0001, 1'b0, 32'h0000_0000, "reset_beats_load"});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0001, 1'b0, 32'h0000_0001, "load_1"});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0002, 1'b1, 32'h0000_0002, "load_2"});

    foreach (vecs[i])
      step(vecs[i].reset, vecs[i].sel, vecs[i].load, vecs[i].shiftin,
           vecs[i].expect_state, vecs[i].name);

    // Flush the loaded 0x2 with shiftin=0 over 64 edges.
    so_ones = 0;
    for (int k = 1; k <= 64; k++)
      step(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, (k == 1) ? 32'h0000_0001 : 32'h0000_0000, "flush");
`ifdef SERIAL_OUT_EN
    n_cmp++;
    if (so_ones != 1) begin
      n_bad++;
      $display("FAIL flush_shiftout_pulse: ones got %0d want 1", so_ones);
    end
`endif

    // Fill from zero with shiftin=1: top k bits set after edge k.
    for (int k = 1; k <= W; k++)
      step(1'b0, 1'b0, 32'h0000_0000, 1'b1, ~(32'hFFFF_FFFF >> k), "fill");

    // Mid-operation reset.
    step(1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, "mid_load");
    step(1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h52D2_D2D2, "mid_shift1");
    step(1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h2969_6969, "mid_shift2");
    step(1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h14B4_B4B4, "mid_shift3");
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, "mid_reset");
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h1234_5678, "post_reset_load");

    // Back-to-back mode switching with load held.
    step(1'b0, 1'b1, 32'h8000_0001, 1'b0, 32'h8000_0001, "alt_load");
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 32'h8000_0001, 1'b0, 32'h4000_0000, "alt_shift");
      step(1'b0, 1'b1, 32'h8000_0001, 1'b0, 32'h8000_0001, "alt_reload");
    end

    // Shiftin value enters the MSB on a single shift.
    step(1'b0, 1'b1, 32'h0000_00F0, 1'b0, 32'h0000_00F0, "msb_load");
    step(1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h8000_0078, "msb_in1");
    step(1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h4000_003C, "msb_in0");

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: left %0d want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_shift_load_reg32
